// File: rtl/net_owner_handoff_ctrl_if.sv
// O-side stream handshake observed by the handoff controller plus the mux/reset controls it drives.
interface net_owner_handoff_ctrl_if;
  logic [3:0] ch_valid;
  logic [3:0] ch_ready;
  logic [3:0] ch_last;
  logic [3:0] ch_en;
  logic       sel_trusted;
  logic       o_aresetn;

  modport master (
    input  ch_valid, ch_ready, ch_last,
    output ch_en, sel_trusted, o_aresetn
  );

  modport slave (
    output ch_valid, ch_ready, ch_last,
    input  ch_en, sel_trusted, o_aresetn
  );
endinterface

// File: rtl/net_owner_handoff_ctrl.sv
// Sequences U/T ownership of the shared network interface: drain open packets, scrub, reconnect.
// Optional forced-drain timeout is enabled by defining NET_HANDOFF_TIMEOUT_EN.
module net_owner_handoff_ctrl #(
  parameter int unsigned SCRUB_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            req_trusted,
  input  logic                            clr_status,
  net_owner_handoff_ctrl_if.master        ch,
  output logic                            busy,
  output logic                            timeout_flag
);

  localparam int unsigned SCW = $clog2(SCRUB_CYCLES + 1);

  typedef enum logic [1:0] {OWN_U, OWN_T, DRAIN, SCRUB} state_t;

  state_t         state, state_nxt;
  logic           target, target_nxt;
  logic [SCW-1:0] scrub_cnt, scrub_cnt_nxt;
  logic [3:0]     in_pkt, in_pkt_nxt, in_pkt_upd, accepted;
  logic [3:0]     ch_en_q;
  logic           sel_q;
  logic           aresetn_q;

  assign ch.ch_en       = ch_en_q;
  assign ch.sel_trusted = sel_q;
  assign ch.o_aresetn   = aresetn_q;

`ifdef NET_HANDOFF_TIMEOUT_EN
  localparam int unsigned DCW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DCW-1:0] drain_cnt;
  logic           tmo_hit;
`endif

  always_comb begin
    accepted      = ch.ch_valid & ch.ch_ready & ch_en_q;
    in_pkt_upd    = (in_pkt | (accepted & ~ch.ch_last)) & ~(accepted & ch.ch_last);
    state_nxt     = state;
    target_nxt    = target;
    scrub_cnt_nxt = scrub_cnt;
    in_pkt_nxt    = in_pkt_upd;
`ifdef NET_HANDOFF_TIMEOUT_EN
    tmo_hit       = 1'b0;
`endif
    unique case (state)
      OWN_U: begin
        if (req_trusted) begin
          target_nxt = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      OWN_T: begin
        if (!req_trusted) begin
          target_nxt = 1'b0;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        // Exit test uses this cycle's beats so a closing last beat leaves DRAIN on the same edge.
        if (req_trusted == sel_q) begin
          state_nxt = sel_q ? OWN_T : OWN_U;
        end else if (in_pkt_upd == '0) begin
          state_nxt     = SCRUB;
          scrub_cnt_nxt = SCW'(SCRUB_CYCLES);
          in_pkt_nxt    = '0;
        end
`ifdef NET_HANDOFF_TIMEOUT_EN
        else if (drain_cnt == DCW'(DRAIN_TIMEOUT - 1)) begin
          state_nxt     = SCRUB;
          scrub_cnt_nxt = SCW'(SCRUB_CYCLES);
          in_pkt_nxt    = '0;
          tmo_hit       = 1'b1;
        end
`endif
      end
      SCRUB: begin
        in_pkt_nxt = '0;
        if (scrub_cnt == SCW'(1)) begin
          state_nxt = target ? OWN_T : OWN_U;
        end else begin
          scrub_cnt_nxt = scrub_cnt - SCW'(1);
        end
      end
      default: state_nxt = SCRUB;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= SCRUB;
      target    <= 1'b0;
      scrub_cnt <= SCW'(SCRUB_CYCLES);
      in_pkt    <= '0;
      sel_q     <= 1'b0;
      aresetn_q <= 1'b0;
      ch_en_q   <= '0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      scrub_cnt <= scrub_cnt_nxt;
      in_pkt    <= in_pkt_nxt;
      unique case (state_nxt)
        OWN_U: begin
          sel_q     <= 1'b0;
          ch_en_q   <= '1;
          aresetn_q <= 1'b1;
          busy      <= 1'b0;
        end
        OWN_T: begin
          sel_q     <= 1'b1;
          ch_en_q   <= '1;
          aresetn_q <= 1'b1;
          busy      <= 1'b0;
        end
        DRAIN: begin
          sel_q     <= sel_q;
          ch_en_q   <= in_pkt_nxt;
          aresetn_q <= 1'b1;
          busy      <= 1'b1;
        end
        default: begin
          sel_q     <= target_nxt;
          ch_en_q   <= '0;
          aresetn_q <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

`ifdef NET_HANDOFF_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drain_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state != DRAIN) begin
        drain_cnt <= '0;
      end else if (drain_cnt != DCW'(DRAIN_TIMEOUT)) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end
      if (tmo_hit) begin
        timeout_flag <= 1'b1;
      end else if (clr_status) begin
        timeout_flag <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = clr_status | (DRAIN_TIMEOUT == 0);
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_net_owner_handoff_ctrl.sv
// Bench for net_owner_handoff_ctrl: directed handoff scenarios plus random traffic against a reference model.
module tb_net_owner_handoff_ctrl;
  localparam int unsigned SC = 4;
  localparam int unsigned DT = 16;

  // Observation vector: {ch_en[3:0], sel_trusted, o_aresetn, busy}
  localparam logic [6:0] E_RESET    = 7'b0000_0_0_1;
  localparam logic [6:0] E_OWN_U    = 7'b1111_0_1_0;
  localparam logic [6:0] E_OWN_T    = 7'b1111_1_1_0;
  localparam logic [6:0] E_DRAIN_U0 = 7'b0000_0_1_1;
  localparam logic [6:0] E_SCRUB_T  = 7'b0000_1_0_1;
  localparam logic [6:0] E_SCRUB_U  = 7'b0000_0_0_1;
  localparam logic [6:0] E_DR_TXD   = 7'b0010_0_1_1;
  localparam logic [6:0] E_DR_RXD   = 7'b0100_0_1_1;

  logic clk = 1'b0;
  logic resetn, req_trusted, clr_status;
  logic busy, timeout_flag;
  int   errors = 0;
  int   checks = 0;

  net_owner_handoff_ctrl_if bus();

  net_owner_handoff_ctrl #(.SCRUB_CYCLES(SC), .DRAIN_TIMEOUT(DT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_trusted  (req_trusted),
    .clr_status   (clr_status),
    .ch           (bus),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = owned, 1 = draining, 2 = scrubbing
  int       m_phase = 2;
  int       m_left = SC;
  int       m_dcnt = 0;
  bit       m_owner = 1'b0;
  bit       m_goal = 1'b0;
  bit [3:0] m_open = '0;
  bit       m_flag = 1'b0;

  function automatic logic [3:0] m_en();
    if (m_phase == 0) return 4'hF;
    if (m_phase == 1) return m_open;
    return 4'h0;
  endfunction

  function automatic logic [6:0] m_obs();
    return {m_en(), m_owner, logic'(m_phase != 2), logic'(m_phase != 0)};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.ch_en, bus.sel_trusted, bus.o_aresetn, busy};
  endfunction

  task automatic model_step();
    bit [3:0] open_after;
    bit [3:0] en;
    bit       set_now;
    set_now = 1'b0;
    if (!resetn) begin
      m_phase = 2; m_left = SC; m_owner = 1'b0; m_goal = 1'b0;
      m_open = '0; m_flag = 1'b0; m_dcnt = 0;
      return;
    end
    en = m_en();
    open_after = m_open;
    for (int i = 0; i < 4; i++)
      if (bus.ch_valid[i] && bus.ch_ready[i] && en[i]) open_after[i] = !bus.ch_last[i];
    if (m_phase == 0) begin
      m_open = open_after;
      if (req_trusted != m_owner) begin
        m_goal = req_trusted; m_phase = 1; m_dcnt = 0;
      end
    end else if (m_phase == 1) begin
      m_dcnt++;
      if (req_trusted == m_owner) begin
        m_phase = 0; m_open = open_after;
      end else if (open_after == 0) begin
        m_phase = 2; m_left = SC; m_owner = m_goal; m_open = '0;
      end else begin
        m_open = open_after;
`ifdef NET_HANDOFF_TIMEOUT_EN
        if (m_dcnt >= DT) begin
          m_phase = 2; m_left = SC; m_owner = m_goal; m_open = '0; set_now = 1'b1;
        end
`endif
      end
    end else begin
      m_open = '0;
      if (m_left <= 1) m_phase = 0;
      else m_left--;
    end
`ifdef NET_HANDOFF_TIMEOUT_EN
    if (set_now) m_flag = 1'b1;
    else if (clr_status) m_flag = 1'b0;
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input logic [3:0] v, input logic [3:0] r, input logic [3:0] l);
    bus.ch_valid = v; bus.ch_ready = r; bus.ch_last = l;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_trusted = 1'b0; clr_status = 1'b0;
    set_ch(4'h0, 4'h0, 4'h0);
    repeat (3) tick();
    checks++;
    if (obs() !== E_RESET) begin errors++; $display("FAIL reset_state: got %b expected %b", obs(), E_RESET); end
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout_flag: got %b expected 0", timeout_flag); end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== E_RESET) begin errors++; $display("FAIL release_scrub[%0d]: got %b expected %b", i, obs(), E_RESET); end
      tick();
    end
    checks++;
    if (obs() !== E_OWN_U) begin errors++; $display("FAIL release_own_u: got %b expected %b", obs(), E_OWN_U); end
  endtask

  task automatic test_handoff_idle();
    int n;
    req_trusted = 1'b1;
    tick();
    checks++;
    if (obs() !== E_DRAIN_U0) begin errors++; $display("FAIL idle_drain: got %b expected %b", obs(), E_DRAIN_U0); end
    tick();
    checks++;
    if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL idle_scrub_entry: got %b expected %b", obs(), E_SCRUB_T); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL idle_scrub_hold[%0d]: got %b expected %b", i, obs(), E_SCRUB_T); end
    end
    tick();
    checks++;
    if (obs() !== E_OWN_T) begin errors++; $display("FAIL idle_own_t: got %b expected %b", obs(), E_OWN_T); end
    req_trusted = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    checks++;
    if (obs() !== E_OWN_U || n != 2 + SC) begin
      errors++; $display("FAIL idle_back_to_u: got %b after %0d cycles expected %b after %0d", obs(), n, E_OWN_U, 2 + SC);
    end
  endtask

  task automatic test_drain_open();
    int n;
    set_ch(4'b0010, 4'b0010, 4'b0000);
    repeat (3) tick();
    set_ch(4'h0, 4'h0, 4'h0);
    req_trusted = 1'b1;
    tick();
    checks++;
    if (obs() !== E_DR_TXD) begin errors++; $display("FAIL drain_en_txd: got %b expected %b", obs(), E_DR_TXD); end
    // rxs tries to start a packet; it must stay blocked
    set_ch(4'b1000, 4'b1000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== E_DR_TXD) begin errors++; $display("FAIL drain_hold[%0d]: got %b expected %b", i, obs(), E_DR_TXD); end
    end
    set_ch(4'b1010, 4'b1010, 4'b0010);
    tick();
    checks++;
    if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL drain_exit_scrub: got %b expected %b", obs(), E_SCRUB_T); end
    set_ch(4'h0, 4'h0, 4'h0);
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    checks++;
    if (obs() !== E_OWN_T) begin errors++; $display("FAIL drain_own_t: got %b expected %b", obs(), E_OWN_T); end
  endtask

  task automatic test_abort();
    int n;
    req_trusted = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    set_ch(4'b0100, 4'b0100, 4'b0000);
    tick();
    set_ch(4'h0, 4'h0, 4'h0);
    req_trusted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== E_DR_RXD) begin errors++; $display("FAIL abort_drain[%0d]: got %b expected %b", i, obs(), E_DR_RXD); end
    end
    req_trusted = 1'b0;
    tick();
    checks++;
    if (obs() !== E_OWN_U) begin errors++; $display("FAIL abort_own_u: got %b expected %b", obs(), E_OWN_U); end
    req_trusted = 1'b1;
    tick();
    checks++;
    if (obs() !== E_DR_RXD) begin errors++; $display("FAIL abort_keeps_open: got %b expected %b", obs(), E_DR_RXD); end
    set_ch(4'b0100, 4'b0100, 4'b0100);
    tick();
    checks++;
    if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL abort_close_scrub: got %b expected %b", obs(), E_SCRUB_T); end
    set_ch(4'h0, 4'h0, 4'h0);
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    req_trusted = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    checks++;
    if (obs() !== E_OWN_U) begin errors++; $display("FAIL abort_return_u: got %b expected %b", obs(), E_OWN_U); end
  endtask

  task automatic test_reset_mid();
    int n;
    req_trusted = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL mid_scrub: got %b expected %b", obs(), E_SCRUB_T); end
    tick();
    resetn = 1'b0;
    tick();
    checks++;
    if (obs() !== E_SCRUB_U) begin errors++; $display("FAIL mid_reset_sel: got %b expected %b", obs(), E_SCRUB_U); end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== E_SCRUB_U) begin errors++; $display("FAIL mid_rescrub[%0d]: got %b expected %b", i, obs(), E_SCRUB_U); end
      tick();
    end
    checks++;
    if (obs() !== E_OWN_U) begin errors++; $display("FAIL mid_own_u: got %b expected %b", obs(), E_OWN_U); end
    tick();
    checks++;
    if (obs() !== E_DRAIN_U0) begin errors++; $display("FAIL mid_rehandoff_drain: got %b expected %b", obs(), E_DRAIN_U0); end
    tick();
    checks++;
    if (obs() !== E_SCRUB_T) begin errors++; $display("FAIL mid_rehandoff_scrub: got %b expected %b", obs(), E_SCRUB_T); end
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    checks++;
    if (obs() !== E_OWN_T) begin errors++; $display("FAIL mid_own_t: got %b expected %b", obs(), E_OWN_T); end
  endtask

`ifdef NET_HANDOFF_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    req_trusted = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
    set_ch(4'b0001, 4'b0001, 4'b0000);
    tick();
    set_ch(4'b0001, 4'b0000, 4'b0000);
    req_trusted = 1'b1;
    tick();
    repeat (DT - 1) tick();
    checks++;
    if (obs() !== 7'b0001_0_1_1 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL timeout_last_drain: got %b/%b expected %b/0", obs(), timeout_flag, 7'b0001_0_1_1);
    end
    tick();
    checks++;
    if (obs() !== E_SCRUB_T || timeout_flag !== 1'b1) begin
      errors++; $display("FAIL timeout_forced: got %b/%b expected %b/1", obs(), timeout_flag, E_SCRUB_T);
    end
    set_ch(4'h0, 4'h0, 4'h0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_flag); end
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < 40);
  endtask
`endif

  task automatic test_random();
    logic [7:0] got, want;
    for (int i = 0; i < 800; i++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) req_trusted = ~req_trusted;
      clr_status = ($urandom_range(0, 7) == 0);
      bus.ch_valid = 4'($urandom);
      bus.ch_ready = 4'($urandom);
      for (int c = 0; c < 4; c++) bus.ch_last[c] = ($urandom_range(0, 2) == 0);
      tick();
      got  = {obs(), timeout_flag};
      want = {m_obs(), m_flag};
      checks++;
      if (got !== want) begin errors++; $display("FAIL random[%0d]: got %b expected %b", i, got, want); end
    end
    resetn = 1'b1;
    clr_status = 1'b0;
    set_ch(4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_handoff_idle();
    test_drain_open();
    test_abort();
    test_reset_mid();
`ifdef NET_HANDOFF_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
